// File: rtl/alarma_pkg.sv
// Shared pattern codes, sequencer state encoding and slot helpers for the
// alarm tone sequencer.
package alarma_pkg;

    localparam logic [1:0] PAT_CONT   = 2'b00;
    localparam logic [1:0] PAT_BEEP   = 2'b01;
    localparam logic [1:0] PAT_SIREN  = 2'b10;
    localparam logic [1:0] PAT_TRIPLE = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Bit n set means slot n of the 8-slot triple-beep frame sounds.
    localparam logic [7:0] TRIPLE_MASK = 8'b0001_0101;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic slot_sounds(input logic [1:0] pat, input logic [2:0] idx);
        case (pat)
            PAT_CONT:  return 1'b1;
            PAT_BEEP:  return ~idx[0];
            PAT_SIREN: return 1'b1;
            default:   return TRIPLE_MASK[idx];
        endcase
    endfunction

    function automatic logic [2:0] slot_next(input logic [1:0] pat, input logic [2:0] idx);
        if (pat == PAT_TRIPLE)
            return idx + 3'd1;
        return {2'b00, ~idx[0]};
    endfunction

endpackage

// File: rtl/alarma_tone_div.sv
// Half-period divider: toggles wave every selected half-period while run is high;
// clear reloads the phase to force_level, idle holds the wave low.
module alarma_tone_div
    import alarma_pkg::*;
#(
    parameter int TONE_A_HALF = 12500,
    parameter int TONE_B_HALF = 25000
) (
    input  logic clk,
    input  logic reset,
    input  logic half_sel,
    input  logic clear,
    input  logic force_level,
    input  logic run,
    output logic wave
);

    localparam int MAX_HALF = (TONE_A_HALF > TONE_B_HALF) ? TONE_A_HALF : TONE_B_HALF;
    localparam int CNT_W    = cnt_width(MAX_HALF);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(TONE_A_HALF - 1);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(TONE_B_HALF - 1);

    logic [CNT_W-1:0] tone_cnt;
    logic [CNT_W-1:0] tone_last;

    assign tone_last = half_sel ? B_LAST : A_LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tone_cnt <= '0;
            wave     <= 1'b0;
        end else if (clear) begin
            tone_cnt <= '0;
            wave     <= force_level;
        end else if (run) begin
            if (tone_cnt == tone_last) begin
                tone_cnt <= '0;
                wave     <= ~wave;
            end else begin
                tone_cnt <= tone_cnt + CNT_W'(1);
            end
        end else begin
            tone_cnt <= '0;
            wave     <= 1'b0;
        end
    end

endmodule

// File: rtl/alarma_tone_seq.sv
// Alarm tone sequencer: slot/cadence FSM driving one tone divider.
//   state | meaning
//   IDLE  | enable[0]=0, outputs low, counters cleared
//   RUN   | sequencing slots of the registered pattern
module alarma_tone_seq
    import alarma_pkg::*;
#(
    parameter int TONE_A_HALF = 12500,
    parameter int TONE_B_HALF = 25000,
    parameter int SLOT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] enable,
    output logic       clkout,
    output logic       active
);

    if (TONE_A_HALF < 1 || TONE_B_HALF < 1 || SLOT_CYCLES < 2) begin : g_bad_params
        $error("alarma_tone_seq: TONE_*_HALF must be >= 1 and SLOT_CYCLES >= 2");
    end

    localparam int SLOT_W = cnt_width(SLOT_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);

    seq_state_t        state_q, state_d;
    logic [2:0]        slot_idx_q, slot_idx_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]        pat_q, pat_d;
    logic              active_q, active_d;
    logic              div_clear, div_force, div_run, half_sel;
    logic              en_on;
    logic [1:0]        pat_in;
    logic [2:0]        idx_nxt;
    logic              unused_enable;

    assign en_on         = enable[0];
    assign pat_in        = enable[2:1];
    assign unused_enable = ^enable[7:3];
    assign half_sel      = (pat_q == PAT_SIREN) && slot_idx_q[0];
    assign idx_nxt       = slot_next(pat_q, slot_idx_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            slot_idx_q <= '0;
            slot_cnt_q <= '0;
            pat_q      <= PAT_CONT;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_idx_q <= slot_idx_d;
            slot_cnt_q <= slot_cnt_d;
            pat_q      <= pat_d;
            active_q   <= active_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_idx_d = slot_idx_q;
        slot_cnt_d = slot_cnt_q;
        pat_d      = pat_q;
        active_d   = active_q;
        div_clear  = 1'b0;
        div_force  = 1'b0;
        div_run    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_on) begin
                    state_d    = RUN;
                    pat_d      = pat_in;
                    slot_idx_d = '0;
                    slot_cnt_d = '0;
                    active_d   = 1'b1;
                    div_clear  = 1'b1;
                    div_force  = 1'b1;
                end
            end
            RUN: begin
                // Priority: disable, then pattern restart, then slot boundary.
                if (!en_on) begin
                    state_d    = IDLE;
                    slot_idx_d = '0;
                    slot_cnt_d = '0;
                    active_d   = 1'b0;
                    div_clear  = 1'b1;
                end else if (pat_in != pat_q) begin
                    pat_d      = pat_in;
                    slot_idx_d = '0;
                    slot_cnt_d = '0;
                    active_d   = 1'b1;
                    div_clear  = 1'b1;
                    div_force  = 1'b1;
                end else begin
                    div_run = slot_sounds(pat_q, slot_idx_q);
                    if (slot_cnt_q == SLOT_LAST) begin
                        slot_cnt_d = '0;
                        // Continuous tone runs free across slot boundaries.
                        if (pat_q != PAT_CONT) begin
                            slot_idx_d = idx_nxt;
                            active_d   = slot_sounds(pat_q, idx_nxt);
                            div_clear  = 1'b1;
                            div_force  = slot_sounds(pat_q, idx_nxt);
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    alarma_tone_div #(
        .TONE_A_HALF (TONE_A_HALF),
        .TONE_B_HALF (TONE_B_HALF)
    ) u_tone_div (
        .clk         (clk),
        .reset       (reset),
        .half_sel    (half_sel),
        .clear       (div_clear),
        .force_level (div_force),
        .run         (div_run),
        .wave        (clkout)
    );

    assign active = active_q;

endmodule

// File: tb/tb_alarma_tone_seq.sv
// Scoreboard bench for alarma_tone_seq: a cycle-indexed cadence model pushes
// the expected {clkout, active} for each edge, compared after that edge.
module tb_alarma_tone_seq;

    logic       clk;
    logic       reset;
    logic [7:0] enable;
    logic       clkout;
    logic       active;

    int tests = 0;
    int fails = 0;

    logic [1:0] exp_q[$];
    bit         m_run = 1'b0;
    logic [1:0] m_pat = 2'b00;
    int         m_t   = 0;

    alarma_tone_seq #(
        .TONE_A_HALF (3),
        .TONE_B_HALF (5),
        .SLOT_CYCLES (20)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clkout (clkout),
        .active (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got {clkout,active}=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_out(input logic [1:0] pat, input int t);
        int  slot, w, idx, half;
        bit  snd;
        if (pat == 2'b00)
            return {((t / 3) % 2) == 0, 1'b1};
        slot = t / 20;
        w    = t % 20;
        idx  = (pat == 2'b11) ? slot % 8 : slot % 2;
        case (pat)
            2'b01:   snd = (idx == 0);
            2'b10:   snd = 1'b1;
            default: snd = (idx == 0) || (idx == 2) || (idx == 4);
        endcase
        half = (pat == 2'b10 && idx == 1) ? 5 : 3;
        return {snd && (((w / half) % 2) == 0), snd};
    endfunction

    task automatic step(input logic [7:0] e, input string tag);
        logic [1:0] exp;
        @(negedge clk);
        enable = e;
        if (!e[0]) begin
            m_run = 1'b0;
        end else if (!m_run || e[2:1] != m_pat) begin
            m_run = 1'b1;
            m_pat = e[2:1];
            m_t   = 0;
        end else begin
            m_t++;
        end
        exp_q.push_back(m_run ? model_out(m_pat, m_t) : 2'b00);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, {clkout, active}, 2'bxx);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, {clkout, active}, exp);
        end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 8'h01;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_hold", {clkout, active}, 2'b00);
        end
        #1 reset = 1'b1;
        step(8'h01, "reset_release");

        repeat (110) step(8'h01, "cont");
        repeat (3)   step(8'h00, "cont_off");

        repeat (90)  step(8'h03, "beep");
        step(8'h00, "beep_off");

        repeat (60)  step(8'h05, "siren");
        step(8'h00, "siren_off");

        repeat (170) step(8'h07, "triple");
        step(8'h00, "triple_off");
        repeat (170) step(8'hF7, "triple_rsv");
        step(8'h00, "triple_rsv_off");

        repeat (20)  step(8'h03, "beep_pre_bnd");
        step(8'h00, "off_at_boundary");
        step(8'h00, "off_idle");

        repeat (28)  step(8'h03, "chg_beep");
        repeat (50)  step(8'h05, "chg_siren");
        step(8'h00, "chg_off");

        repeat (2)   step(8'h01, "pre_async");
        #1 reset = 1'b0;
        #1 chk("async_reset", {clkout, active}, 2'b00);
        m_run = 1'b0;
        #1 reset = 1'b1;
        step(8'h01, "async_release");
        repeat (5) step(8'h01, "async_cont");

        chk("queue_drained", 2'(exp_q.size()), 2'b00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
